// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package instruction_fetch_unit_pkg;

    localparam int WORD_SIZE = 19;
    localparam int IM_ADDR_W = 10;
    localparam int IM_DEPTH  = 1024;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } fetch_state_t;

    typedef struct packed {
        logic [IM_ADDR_W-1:0] pc;
        logic [WORD_SIZE-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_unit_fetch_buffer.sv
// Prefetch FIFO of {pc, instr} entries with flush, push, pop and occupancy.
module fetch_buffer
    import instruction_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic         CLK,
    input  logic         RESET_N,
    input  logic         i_flush,
    input  logic         i_push,
    input  fetch_entry_t i_data,
    input  logic         i_pop,
    output fetch_entry_t o_head,
    output logic         o_valid,
    output logic [CW-1:0] o_occ
);

    localparam int PW = $clog2(DEPTH);

    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_wr;
    logic [PW-1:0] r_rd;
    logic [CW-1:0] r_occ;
    logic          w_push;
    logic          w_pop;

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_pop  = i_pop && (r_occ != '0);
    assign w_push = i_push && !i_flush &&
                    ((r_occ != CW'(DEPTH)) || w_pop);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr  <= '0;
            r_rd  <= '0;
            r_occ <= '0;
        end else if (i_flush) begin
            r_wr  <= r_rd;
            r_occ <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= i_data;
                r_wr        <= f_inc(r_wr);
            end
            if (w_pop) r_rd <= f_inc(r_rd);
            unique case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + CW'(1);
                2'b01:   r_occ <= r_occ - CW'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd];
    assign o_valid = (r_occ != '0);
    assign o_occ   = r_occ;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: PC, IM read issue, prefetch buffer, redirect handling.
// Optional perf counters enabled by defining IFU_PERF_CNT_EN.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [IM_ADDR_W-1:0] RESET_PC  = 10'h000,
    parameter int                   BUF_DEPTH = 2
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic                 fetch_en,
    input  logic                 redirect,
    input  logic [IM_ADDR_W-1:0] redirect_pc,
    output logic                 im_rd_en,
    output logic [IM_ADDR_W-1:0] im_addr,
    input  logic [WORD_SIZE-1:0] im_rdata,
    output logic                 instr_valid,
    input  logic                 instr_ready,
    output logic [WORD_SIZE-1:0] instr_out,
    output logic [IM_ADDR_W-1:0] instr_pc,
    output logic                 fetch_busy,
    output logic [31:0]          perf_fetched,
    output logic [31:0]          perf_bubbles
);

    localparam int CW = $clog2(BUF_DEPTH + 1);

    fetch_state_t         r_state;
    fetch_state_t         w_state_nxt;
    logic [IM_ADDR_W-1:0] r_pc;
    logic [IM_ADDR_W-1:0] r_ret_pc;
    logic                 r_inflight;
    logic                 r_stale;
    logic                 w_issue;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_valid;
    logic [CW-1:0]        w_occ;
    fetch_entry_t         w_head;
    fetch_entry_t         w_ret;

    assign w_pop  = w_valid && instr_ready;
    // A word returning in a redirect cycle belongs to the old path.
    assign w_push = r_inflight && !r_stale && !redirect;
    assign w_ret  = '{pc: r_ret_pc, instr: im_rdata};

    always_comb begin
        w_issue = 1'b0;
        if (r_state == RUN && !redirect)
            w_issue = (int'(w_occ) + int'(r_inflight)) <
                      (BUF_DEPTH + int'(w_pop));
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (fetch_en) w_state_nxt = RUN;
            RUN:     if (!fetch_en) w_state_nxt = DRAIN;
            DRAIN: begin
                if (fetch_en)         w_state_nxt = RUN;
                else if (!r_inflight) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state    <= IDLE;
            r_pc       <= RESET_PC;
            r_ret_pc   <= '0;
            r_inflight <= 1'b0;
            r_stale    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_inflight <= w_issue;
            r_stale    <= redirect && r_inflight;
            if (redirect)     r_pc <= redirect_pc;
            else if (w_issue) r_pc <= r_pc + 1'b1;
            if (w_issue) r_ret_pc <= r_pc;
        end
    end

    fetch_buffer #(
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .i_flush (redirect),
        .i_push  (w_push),
        .i_data  (w_ret),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_valid (w_valid),
        .o_occ   (w_occ)
    );

    assign im_rd_en    = w_issue;
    assign im_addr     = r_pc;
    assign instr_valid = w_valid;
    assign instr_out   = w_head.instr;
    assign instr_pc    = w_head.pc;
    assign fetch_busy  = (r_state != IDLE) || r_inflight;

`ifdef IFU_PERF_CNT_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_bubbles;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_perf_fetched <= '0;
            r_perf_bubbles <= '0;
        end else begin
            if (w_pop) r_perf_fetched <= r_perf_fetched + 32'd1;
            if (r_state == RUN && !w_valid)
                r_perf_bubbles <= r_perf_bubbles + 32'd1;
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_bubbles = r_perf_bubbles;
`else
    assign perf_fetched = 32'h0;
    assign perf_bubbles = 32'h0;
`endif

endmodule
